// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780 4-bit interface sequencer.
// Runs the power-on initialisation sequence, then accepts bytes over a valid/ready handshake.
// Each byte goes out as two nibbles. Every nibble takes three one-cycle states: setup, strobe
// and hold. The byte is then followed by the LCD execution wait.
//
// Ports:
//   refclk     in   reference clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_data    in   byte to write
//   in_rs      in   register select for in_data (1 = data, 0 = command)
//   in_valid   in   in_data/in_rs valid
//   in_ready   out  sequencer can accept a byte (only after init)
//   init_done  out  init sequence complete, sticky until reset
//   lcd_data   out  LCD D7..D4
//   lcd_rs     out  LCD RS
//   lcd_e      out  LCD E strobe
//
// Optional feature macro: LCD_SEQ_LINEFEED_EN.
// When it is defined, a data byte 0x0A is sent as command 0xC0 (cursor to line 2, column 0).
module lcd_sequencer #(
   parameter int unsigned T_POWERUP = 30000,
   parameter int unsigned T_INIT1   = 8200,
   parameter int unsigned T_INIT2   = 200,
   parameter int unsigned T_CMD     = 80,
   parameter int unsigned T_CLEAR   = 3280,
   parameter int unsigned CNT_W     = 15
) (
   input  logic       refclk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_rs,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       init_done,
   output logic [3:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_e
);

   localparam logic [CNT_W-1:0] CntPowerup = CNT_W'(T_POWERUP);
   localparam logic [CNT_W-1:0] CntInit1   = CNT_W'(T_INIT1);
   localparam logic [CNT_W-1:0] CntInit2   = CNT_W'(T_INIT2);
   localparam logic [CNT_W-1:0] CntCmd     = CNT_W'(T_CMD);
   localparam logic [CNT_W-1:0] CntClear   = CNT_W'(T_CLEAR);

   typedef enum logic [2:0] {
      StPwrup, StInitNib, StInitByte, StNsetup, StNstrobe, StNhold, StWait, StIdle
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic [3:0]       step_q, step_d;
   logic [3:0]       lo_nib_q, lo_nib_d;
   logic             lo_pend_q, lo_pend_d;
   logic [3:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             e_q, ready_q, done_q, done_d;

   logic             cnt_last;
   logic [7:0]       init_val;
   logic [CNT_W-1:0] init_wait;
   logic [7:0]       acc_val;
   logic             acc_rs;
   logic [CNT_W-1:0] acc_wait;

   // A wait of T cycles leaves its state on the T-th edge after entry.
   assign cnt_last = (cnt_q <= CNT_W'(1));

   // Init steps 0..3 are single nibbles (low half of init_val). Steps 4..8 are full bytes.
   always_comb begin
      init_val  = 8'h0C;
      init_wait = CntCmd;
      case (step_q)
         4'd0: begin init_val = 8'h03; init_wait = CntInit1; end
         4'd1: begin init_val = 8'h03; init_wait = CntInit2; end
         4'd2: begin init_val = 8'h03; init_wait = CntCmd;   end
         4'd3: begin init_val = 8'h02; init_wait = CntCmd;   end
         4'd4: begin init_val = 8'h28; init_wait = CntCmd;   end
         4'd5: begin init_val = 8'h08; init_wait = CntCmd;   end
         4'd6: begin init_val = 8'h01; init_wait = CntClear; end
         4'd7: begin init_val = 8'h06; init_wait = CntCmd;   end
         default: begin init_val = 8'h0C; init_wait = CntCmd; end
      endcase
   end

   // Byte actually written for an accepted request, and the wait that follows it.
   always_comb begin
      acc_val = in_data;
      acc_rs  = in_rs;
`ifdef LCD_SEQ_LINEFEED_EN
      if (in_rs && (in_data == 8'h0A)) begin
         acc_val = 8'hC0;
         acc_rs  = 1'b0;
      end
`endif
      // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
      if (!acc_rs && (acc_val inside {8'h01, 8'h02, 8'h03})) acc_wait = CntClear;
      else                                                   acc_wait = CntCmd;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wait_d    = wait_q;
      step_d    = step_q;
      lo_nib_d  = lo_nib_q;
      lo_pend_d = lo_pend_q;
      data_d    = data_q;
      rs_d      = rs_q;
      done_d    = done_q;
      case (state_q)
         StPwrup: begin
            if (cnt_last) state_d = StInitNib;
            else          cnt_d   = cnt_q - CNT_W'(1);
         end
         StInitNib: begin
            data_d    = init_val[3:0];
            rs_d      = 1'b0;
            lo_pend_d = 1'b0;
            wait_d    = init_wait;
            state_d   = StNsetup;
         end
         StInitByte: begin
            data_d    = init_val[7:4];
            lo_nib_d  = init_val[3:0];
            rs_d      = 1'b0;
            lo_pend_d = 1'b1;
            wait_d    = init_wait;
            state_d   = StNsetup;
         end
         StNsetup:  state_d = StNstrobe;
         StNstrobe: state_d = StNhold;
         StNhold: begin
            if (lo_pend_q) begin
               data_d    = lo_nib_q;
               lo_pend_d = 1'b0;
               state_d   = StNsetup;
            end else begin
               cnt_d   = wait_q;
               state_d = StWait;
            end
         end
         StWait: begin
            if (!cnt_last) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (done_q) begin
               state_d = StIdle;
            end else if (step_q == 4'd8) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               step_d  = step_q + 4'd1;
               state_d = (step_q < 4'd3) ? StInitNib : StInitByte;
            end
         end
         StIdle: begin
            if (in_valid) begin
               data_d    = acc_val[7:4];
               lo_nib_d  = acc_val[3:0];
               rs_d      = acc_rs;
               lo_pend_d = 1'b1;
               wait_d    = acc_wait;
               state_d   = StNsetup;
            end
         end
         default: state_d = StPwrup;
      endcase
   end

   // Outputs are registered from the next state, so they change exactly on the transition edge.
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         state_q   <= StPwrup;
         cnt_q     <= CntPowerup;
         wait_q    <= '0;
         step_q    <= '0;
         lo_nib_q  <= '0;
         lo_pend_q <= 1'b0;
         data_q    <= '0;
         rs_q      <= 1'b0;
         e_q       <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wait_q    <= wait_d;
         step_q    <= step_d;
         lo_nib_q  <= lo_nib_d;
         lo_pend_q <= lo_pend_d;
         data_q    <= data_d;
         rs_q      <= rs_d;
         e_q       <= (state_d == StNstrobe);
         ready_q   <= (state_d == StIdle);
         done_q    <= done_d;
      end
   end

   assign lcd_data  = data_q;
   assign lcd_rs    = rs_q;
   assign lcd_e     = e_q;
   assign in_ready  = ready_q;
   assign init_done = done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer, using small timing parameters.
module tb_lcd_sequencer;

   localparam int unsigned TCmd   = 4;
   localparam int unsigned TClear = 12;

   logic       refclk = 1'b0;
   logic       reset  = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_rs = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready, init_done, lcd_rs, lcd_e;
   logic [3:0] lcd_data;

   lcd_sequencer #(
      .T_POWERUP(20), .T_INIT1(10), .T_INIT2(5), .T_CMD(TCmd), .T_CLEAR(TClear), .CNT_W(15)
   ) dut (
      .refclk   (refclk),
      .reset    (reset),
      .in_data  (in_data),
      .in_rs    (in_rs),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .init_done(init_done),
      .lcd_data (lcd_data),
      .lcd_rs   (lcd_rs),
      .lcd_e    (lcd_e)
   );

   always #5 refclk = ~refclk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned strobes = 0;
   int unsigned early_ready = 0;
   logic [4:0]  exp_q[$];   // expected {rs, nibble} per E strobe

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: what the LCD should see, derived from the byte-level rules.
   task automatic push_byte(input logic [7:0] b, input logic rs);
      exp_q.push_back({rs, b[7:4]});
      exp_q.push_back({rs, b[3:0]});
   endtask

   task automatic push_init();
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h02);
      push_byte(8'h28, 1'b0);
      push_byte(8'h08, 1'b0);
      push_byte(8'h01, 1'b0);
      push_byte(8'h06, 1'b0);
      push_byte(8'h0C, 1'b0);
   endtask

   task automatic model_byte(input logic [7:0] d, input logic rs, output int unsigned lat);
      logic [7:0] v;
      logic       r;
      v = d;
      r = rs;
`ifdef LCD_SEQ_LINEFEED_EN
      if (rs && d == 8'h0A) begin
         v = 8'hC0;
         r = 1'b0;
      end
`endif
      push_byte(v, r);
      lat = 6 + ((!rs && d >= 8'h01 && d <= 8'h03) ? TClear : TCmd);
   endtask

   // Strobe monitor: every rising E is compared against the next expected nibble.
   initial begin
      logic prev_e;
      logic [4:0] e;
      prev_e = 1'b0;
      forever begin
         @(negedge refclk);
         if (lcd_e && !prev_e) begin
            strobes++;
            check_val("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_val("strobe_rs_nibble", {27'd0, lcd_rs, lcd_data}, {27'd0, e});
            end
         end
         prev_e = lcd_e;
         if (in_ready && !init_done) early_ready++;
      end
   end

   task automatic wait_ready(input string tag);
      int unsigned n;
      n = 0;
      while (!in_ready && n < 2000) begin
         @(negedge refclk);
         n++;
      end
      check_val({tag, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   // Called at a negedge with in_ready high; in_valid is toggled randomly while busy.
   task automatic send_byte(input logic [7:0] d, input logic rs, input string tag);
      int unsigned lat, exp_lat;
      in_data  = d;
      in_rs    = rs;
      in_valid = 1'b1;
      model_byte(d, rs, exp_lat);
      @(negedge refclk);
      lat = 0;
      while (!in_ready && lat < 100) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         in_rs    = 1'($urandom_range(0, 1));
         @(negedge refclk);
         lat++;
      end
      in_valid = 1'b0;
      check_val({tag, "_latency"}, lat, exp_lat);
      check_val({tag, "_nibbles_left"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int unsigned lat, exp_lat;
      logic [7:0] hb[3];
      logic       hr[3];
      repeat (3) @(negedge refclk);
      check_val("rst_lcd_data", {28'd0, lcd_data}, 32'd0);
      check_val("rst_lcd_rs", 32'(lcd_rs), 32'd0);
      check_val("rst_lcd_e", 32'(lcd_e), 32'd0);
      check_val("rst_in_ready", 32'(in_ready), 32'd0);
      check_val("rst_init_done", 32'(init_done), 32'd0);

      push_init();
      strobes = 0;
      reset = 1'b0;
      wait_ready("init");
      check_val("init_strobes", strobes, 32'd14);
      check_val("init_done", 32'(init_done), 32'd1);
      check_val("init_left", exp_q.size(), 32'd0);

      send_byte(8'h09, 1'b1, "data09");
      send_byte(8'h01, 1'b0, "cmd01");
      send_byte(8'h80, 1'b0, "cmd80");
      send_byte(8'h0A, 1'b1, "data0a");
      send_byte(8'h02, 1'b0, "cmd02");
      send_byte(8'h03, 1'b0, "cmd03");
      send_byte(8'h01, 1'b1, "data01");
      for (int i = 0; i < 25; i++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         send_byte(d, 1'($urandom_range(0, 1)), "rand");
      end

      // in_valid held high across three different bytes.
      hb[0] = 8'h41; hr[0] = 1'b1;
      hb[1] = 8'h01; hr[1] = 1'b0;
      hb[2] = 8'hC5; hr[2] = 1'b0;
      strobes = 0;
      for (int i = 0; i < 3; i++) begin
         in_data  = hb[i];
         in_rs    = hr[i];
         in_valid = 1'b1;
         model_byte(hb[i], hr[i], exp_lat);
         @(negedge refclk);
         lat = 0;
         while (!in_ready && lat < 100) begin
            @(negedge refclk);
            lat++;
         end
         check_val("hold_latency", lat, exp_lat);
      end
      in_valid = 1'b0;
      repeat (4) @(negedge refclk);
      check_val("hold_strobes", strobes, 32'd6);
      check_val("hold_left", exp_q.size(), 32'd0);
      check_val("hold_ready", 32'(in_ready), 32'd1);

      // Reset while E is high in the middle of a byte.
      in_data  = 8'h5A;
      in_rs    = 1'b1;
      in_valid = 1'b1;
      model_byte(8'h5A, 1'b1, exp_lat);
      @(negedge refclk);
      in_valid = 1'b0;
      lat = 0;
      while (!lcd_e && lat < 20) begin
         @(negedge refclk);
         lat++;
      end
      check_val("midbyte_e_seen", 32'(lcd_e), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_val("midrst_lcd_e", 32'(lcd_e), 32'd0);
      check_val("midrst_init_done", 32'(init_done), 32'd0);
      check_val("midrst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge refclk);
      push_init();
      strobes = 0;
      reset = 1'b0;
      wait_ready("reinit");
      check_val("reinit_strobes", strobes, 32'd14);
      check_val("reinit_done", 32'(init_done), 32'd1);
      check_val("reinit_left", exp_q.size(), 32'd0);
      send_byte(8'h0A, 1'b1, "post_reinit_0a");
      send_byte(8'h01, 1'b0, "post_reinit_01");

      check_val("ready_during_init", early_ready, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
